// File: rtl/adder_result_stage_if.sv
// Handshake bundle between the adder, the result stage and its consumer.
// slave is the stage's view; master is the surrounding producer/consumer.
interface adder_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_s;
  logic        in_cf;
  logic        in_of;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_cf;
  logic        out_of;
  logic        out_zf;
  logic        out_sf;
  logic        out_pf;
  logic        out_sub;

  modport slave (
    input  in_valid, in_s, in_cf, in_of, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_cf, out_of, out_zf, out_sf, out_pf, out_sub
  );

  modport master (
    output in_valid, in_s, in_cf, in_of, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_cf, out_of, out_zf, out_sf, out_pf, out_sub
  );
endinterface

// File: rtl/adder_result_stage.sv
// Registered result stage after the 32-bit adder: main + skid register pair,
// flag derivation at capture, and a saturating signed-overflow event counter.
module adder_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_result_stage_if.slave  bus,
  input  logic                 ovf_clr,
  output logic [CNT_W-1:0]     ovf_cnt
);

  typedef struct packed {
    logic [31:0] s;
    logic        cf;
    logic        of;
    logic        sub;
    logic        zf;
    logic        sf;
    logic        pf;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic beat_t make_beat(input logic [31:0] s, input logic cf,
                                      input logic of, input logic sub);
    beat_t b;
    b.s   = s;
    b.cf  = cf;
    b.of  = of;
    b.sub = sub;
    b.zf  = ~|s;
    b.sf  = s[31];
    b.pf  = s[0];
    return b;
  endfunction

  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  beat_t in_beat_s;
  logic  accept_s;
  logic  drain_s;

  assign in_beat_s = make_beat(bus.in_s, bus.in_cf, bus.in_of, bus.in_sub);
  // in_ready depends only on registered skid occupancy, never on out_ready
  assign accept_s  = bus.in_valid & ~skid_vld_q;
  assign drain_s   = main_vld_q & bus.out_ready;

  // Next-state for main/skid storage
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (drain_s) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept_s) begin
        main_d     = in_beat_s;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (!main_vld_q) begin
      if (accept_s) begin
        main_d     = in_beat_s;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_d     = in_beat_s;
        skid_vld_d = 1'b1;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
  end

  // Next-state for overflow counter; clear beats a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && bus.in_of && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = ~skid_vld_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_s     = main_q.s;
  assign bus.out_cf    = main_q.cf;
  assign bus.out_of    = main_q.of;
  assign bus.out_zf    = main_q.zf;
  assign bus.out_sf    = main_q.sf;
  assign bus.out_pf    = main_q.pf;
  assign bus.out_sub   = main_q.sub;
  assign ovf_cnt       = cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench: accepted beats are queued with their expected flags and
// checked in order at the output; overflow counters are modelled alongside.
module tb_adder_result_stage;

  typedef struct {
    logic [31:0] s;
    logic        cf, of, sub, zf, sf, pf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] ovf_cnt;
  logic [1:0]  ovf_cnt2;

  adder_result_stage_if bif ();
  adder_result_stage_if bif2 ();

  adder_result_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  adder_result_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt2)
  );

  assign bif2.in_valid  = bif.in_valid;
  assign bif2.in_s      = bif.in_s;
  assign bif2.in_cf     = bif.in_cf;
  assign bif2.in_of     = bif.in_of;
  assign bif2.in_sub    = bif.in_sub;
  assign bif2.out_ready = bif.out_ready;

  always #5 clk = ~clk;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_cnt2 = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", nm, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs after the edge, then book what the next edge accepts
  task automatic step(input logic v, input logic [31:0] s, input logic cf, input logic of,
                      input logic sub, input logic rdy, input logic clr);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    bif.in_valid  = v;
    bif.in_s      = s;
    bif.in_cf     = cf;
    bif.in_of     = of;
    bif.in_sub    = sub;
    bif.out_ready = rdy;
    ovf_clr       = clr;
    @(negedge clk);
    #1;
    if (rst_n) begin
      acc = v && bif.in_ready;
      if (acc) begin
        e.s = s; e.cf = cf; e.of = of; e.sub = sub;
        e.zf = (s == 32'd0);
        e.sf = (s >= 32'h8000_0000);
        e.pf = (s % 32'd2) == 32'd1;
        q.push_back(e);
      end
      if (clr) begin
        exp_cnt  = 0;
        exp_cnt2 = 0;
      end else if (acc && of) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
  endtask

  // Monitor: output beat must match the oldest outstanding beat
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", {31'd0, bif.in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, bif.out_valid}, {31'd0, q.size() != 0});
        chk("ovf_cnt", {16'd0, ovf_cnt}, exp_cnt);
        chk("ovf_cnt_w2", {30'd0, ovf_cnt2}, exp_cnt2);
        if (bif.out_valid && q.size() != 0) begin
          chk("out_s", bif.out_s, q[0].s);
          chk("out_flags",
              {25'd0, bif.out_cf, bif.out_of, bif.out_sub, bif.out_zf, bif.out_sf, bif.out_pf, 1'b0},
              {25'd0, q[0].cf, q[0].of, q[0].sub, q[0].zf, q[0].sf, q[0].pf, 1'b0});
          if (bif.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] rs;
    bif.in_valid = 1'b0; bif.in_s = 32'd0; bif.in_cf = 1'b0; bif.in_of = 1'b0;
    bif.in_sub = 1'b0; bif.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst_out_s", bif.out_s, 32'd0);
    chk("rst_flags", {26'd0, bif.out_cf, bif.out_of, bif.out_zf, bif.out_sf, bif.out_pf, bif.out_sub}, 32'd0);
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 5-5: zero result, no borrow
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // 0x7FFFFFFF + 1: signed overflow
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // back-to-back stream
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // stall: A then B fill main and skid, then release
    step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // five overflow beats saturate the narrow counter, then clear with an overflow beat
    for (int i = 0; i < 5; i++) step(1'b1, 32'h8000_0010 + i, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 32'd0;
        1:       rs = 32'h8000_0000 | $urandom_range(0, 15);
        default: rs = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, rs, 1'($urandom), $urandom_range(0, 2) == 0,
           1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset with both registers full drops everything
    step(1'b1, 32'h1111_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2222_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, bif.in_ready}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    exp_cnt  = 0;
    exp_cnt2 = 0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("mid_rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    step(1'b1, 32'h3333_0003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
